// File: rtl/store_unit.sv
// RV32 store unit: formats SB/SH/SW data and strobes, issues one write to data memory and waits for its response.
// Optional STORE_TIMEOUT_EN macro adds a watchdog that completes a stuck store with err_o after TIMEOUT_CYCLES.
module store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        store_req_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  store_size_onehot,
    output logic        misaligned_store,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        mem_wvalid_o,
    input  logic        mem_wready_i,
    output logic [31:0] mem_waddr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_bvalid_i,
    input  logic        mem_berr_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t      state, state_next;
    logic        is_byte, is_half, is_word;
    logic [3:0]  strb_fmt;
    logic [31:0] data_fmt;
    logic        accept, complete, timeout, timeout_fire;
    logic        done_next, err_next;

    // Lowest set size bit wins, so malformed multi-hot sizes still decode to one width.
    assign is_byte = store_size_onehot[0];
    assign is_half = store_size_onehot[1] & ~store_size_onehot[0];
    assign is_word = store_size_onehot[2] & ~|store_size_onehot[1:0];

    assign misaligned_store = (is_half & addr_i[0]) | (is_word & |addr_i[1:0]);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a missed branch would infer a latch.
        strb_fmt = 4'h0;
        data_fmt = 32'h0;
        if (is_byte) begin
            strb_fmt = 4'h1 << addr_i[1:0];
            data_fmt = {4{wdata_i[7:0]}};
        end else if (is_half) begin
            strb_fmt = 4'h3 << {addr_i[1], 1'b0};
            data_fmt = {2{wdata_i[15:0]}};
        end else if (is_word) begin
            strb_fmt = 4'hf;
            data_fmt = wdata_i;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (store_req_i && (is_byte || is_half || is_word) && !misaligned_store) begin
                    accept     = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A response before the request is accepted cannot belong to it and is ignored.
                if (mem_wready_i) begin
                    if (mem_bvalid_i) begin
                        complete   = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (mem_bvalid_i) begin
                    complete   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        timeout_fire = timeout & ~complete;
        if (timeout_fire) begin
            state_next = S_IDLE;
        end
        done_next = complete | timeout_fire;
        err_next  = (complete & mem_berr_i) | timeout_fire;
    end

`ifdef STORE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_cnt <= '0;
        end else if (accept) begin
            to_cnt <= '0;
        end else if (state != S_IDLE) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    assign timeout = (state != S_IDLE) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state       <= S_IDLE;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            mem_waddr_o <= 32'h0;
            mem_wdata_o <= 32'h0;
            mem_wstrb_o <= 4'h0;
        end else begin
            state  <= state_next;
            done_o <= done_next;
            err_o  <= err_next;
            if (accept) begin
                mem_waddr_o <= {addr_i[31:2], 2'b00};
                mem_wdata_o <= data_fmt;
                mem_wstrb_o <= strb_fmt;
            end
        end
    end

    assign busy_o       = (state != S_IDLE);
    assign mem_wvalid_o = (state == S_ISSUE);

endmodule

// File: tb/tb_store_unit.sv
// Directed self-checking bench for store_unit: formatting, stalls, errors, back-to-back and reset abort.
// Build with +define+STORE_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=8).
module tb_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        store_req_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [2:0]  store_size_onehot;
    logic        misaligned_store;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        mem_wvalid_o;
    logic        mem_wready_i;
    logic [31:0] mem_waddr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_bvalid_i;
    logic        mem_berr_i;

    int n_tests = 0;
    int n_fail  = 0;

    store_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .store_req_i       (store_req_i),
        .addr_i            (addr_i),
        .wdata_i           (wdata_i),
        .store_size_onehot (store_size_onehot),
        .misaligned_store  (misaligned_store),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .err_o             (err_o),
        .mem_wvalid_o      (mem_wvalid_o),
        .mem_wready_i      (mem_wready_i),
        .mem_waddr_o       (mem_waddr_o),
        .mem_wdata_o       (mem_wdata_o),
        .mem_wstrb_o       (mem_wstrb_o),
        .mem_bvalid_i      (mem_bvalid_i),
        .mem_berr_i        (mem_berr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic present(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
        store_req_i       = 1'b1;
        addr_i            = a;
        wdata_i           = d;
        store_size_onehot = s;
    endtask

    task automatic withdraw();
        store_req_i       = 1'b0;
        store_size_onehot = 3'b000;
    endtask

    initial begin
        rst_i        = 1'b1;
        mem_wready_i = 1'b0;
        mem_bvalid_i = 1'b0;
        mem_berr_i   = 1'b0;
        addr_i       = 32'h0;
        wdata_i      = 32'h0;
        withdraw();
        tick();
        tick();
        check("rst_busy",   busy_o,       0);
        check("rst_done",   done_o,       0);
        check("rst_err",    err_o,        0);
        check("rst_wvalid", mem_wvalid_o, 0);
        check("rst_waddr",  mem_waddr_o,  0);
        check("rst_wdata",  mem_wdata_o,  0);
        check("rst_wstrb",  mem_wstrb_o,  0);
        rst_i = 1'b0;
        tick();

        // SB to the top byte lane, write and response in the same cycle
        present(32'h0000_1003, 32'hAABB_CCDD, 3'b001);
        #1 check("sb_misal", misaligned_store, 0);
        tick();
        withdraw();
        check("sb_wvalid", mem_wvalid_o, 1);
        check("sb_busy",   busy_o,       1);
        check("sb_waddr",  mem_waddr_o,  32'h0000_1000);
        check("sb_wdata",  mem_wdata_o,  32'hDDDD_DDDD);
        check("sb_wstrb",  mem_wstrb_o,  4'b1000);
        check("sb_nodone", done_o,       0);
        mem_wready_i = 1'b1;
        mem_bvalid_i = 1'b1;
        tick();
        mem_wready_i = 1'b0;
        mem_bvalid_i = 1'b0;
        check("sb_done",   done_o,       1);
        check("sb_err",    err_o,        0);
        check("sb_idle",   busy_o,       0);
        check("sb_wvdrop", mem_wvalid_o, 0);
        tick();
        check("sb_pulse",  done_o,       0);

        // SH upper half, response arrives after a cycle in RESP
        present(32'h0000_2002, 32'h1234_5678, 3'b010);
        tick();
        withdraw();
        check("sh_waddr", mem_waddr_o, 32'h0000_2000);
        check("sh_wdata", mem_wdata_o, 32'h5678_5678);
        check("sh_wstrb", mem_wstrb_o, 4'b1100);
        mem_wready_i = 1'b1;
        tick();
        mem_wready_i = 1'b0;
        check("sh_resp_busy",   busy_o,       1);
        check("sh_resp_wvalid", mem_wvalid_o, 0);
        tick();
        check("sh_resp_wait",   done_o,       0);
        mem_bvalid_i = 1'b1;
        tick();
        mem_bvalid_i = 1'b0;
        check("sh_done", done_o, 1);
        check("sh_err",  err_o,  0);
        tick();

        // SH misaligned: dropped with no access and no completion
        present(32'h0000_2001, 32'h1234_5678, 3'b010);
        #1 check("shm_misal", misaligned_store, 1);
        tick();
        withdraw();
        check("shm_wvalid", mem_wvalid_o, 0);
        check("shm_busy",   busy_o,       0);
        check("shm_waddr",  mem_waddr_o,  32'h0000_2000);
        tick();
        check("shm_nodone", done_o, 0);

        // Misaligned word flag on its own
        present(32'h0000_3002, 32'h0, 3'b100);
        #1 check("swm_misal", misaligned_store, 1);
        withdraw();

        // Multi-hot size: byte wins, odd address is legal for a byte
        present(32'h0000_4001, 32'h1122_3344, 3'b111);
        #1 check("pri_misal", misaligned_store, 0);
        tick();
        withdraw();
        check("pri_wstrb", mem_wstrb_o, 4'b0010);
        check("pri_wdata", mem_wdata_o, 32'h4444_4444);
        check("pri_waddr", mem_waddr_o, 32'h0000_4000);
        mem_wready_i = 1'b1;
        mem_bvalid_i = 1'b1;
        tick();
        mem_wready_i = 1'b0;
        mem_bvalid_i = 1'b0;
        check("pri_done", done_o, 1);

        // Request with no size bit is not a store
        present(32'h0000_5000, 32'h5555_5555, 3'b000);
        tick();
        withdraw();
        check("nosize_busy",   busy_o,       0);
        check("nosize_wvalid", mem_wvalid_o, 0);

        // SW held off by wready for 5 cycles; early bvalid and a new request are ignored
        present(32'h0000_3000, 32'hCAFE_F00D, 3'b100);
        tick();
        withdraw();
        for (int i = 0; i < 6; i++) begin
            check("sw_stall_wvalid", mem_wvalid_o, 1);
            check("sw_stall_waddr",  mem_waddr_o,  32'h0000_3000);
            check("sw_stall_wdata",  mem_wdata_o,  32'hCAFE_F00D);
            check("sw_stall_busy",   busy_o,       1);
            check("sw_stall_done",   done_o,       0);
            if (i == 2) begin
                mem_bvalid_i = 1'b1;
                present(32'h0000_7000, 32'h7777_7777, 3'b100);
            end else begin
                mem_bvalid_i = 1'b0;
                withdraw();
            end
            if (i == 5) mem_wready_i = 1'b1;
            tick();
        end
        mem_wready_i = 1'b0;
        check("sw_resp_busy",  busy_o,       1);
        check("sw_resp_wv",    mem_wvalid_o, 0);
        check("sw_resp_waddr", mem_waddr_o,  32'h0000_3000);
        mem_bvalid_i = 1'b1;
        mem_berr_i   = 1'b1;
        tick();
        mem_bvalid_i = 1'b0;
        mem_berr_i   = 1'b0;
        check("sw_berr_done", done_o, 1);
        check("sw_berr_err",  err_o,  1);

        // Back-to-back SW accepted in the done_o cycle
        present(32'h0000_3004, 32'h0102_0304, 3'b100);
        tick();
        withdraw();
        check("b2b_wvalid", mem_wvalid_o, 1);
        check("b2b_waddr",  mem_waddr_o,  32'h0000_3004);
        check("b2b_wdata",  mem_wdata_o,  32'h0102_0304);
        check("b2b_wstrb",  mem_wstrb_o,  4'hF);
        check("b2b_errclr", err_o,        0);
        mem_wready_i = 1'b1;
        mem_bvalid_i = 1'b1;
        tick();
        mem_wready_i = 1'b0;
        mem_bvalid_i = 1'b0;
        check("b2b_done", done_o, 1);
        check("b2b_err",  err_o,  0);
        check("b2b_idle", busy_o, 0);
        tick();

        // Reset while waiting for the response aborts silently
        present(32'h0000_6000, 32'hDEAD_BEEF, 3'b100);
        tick();
        withdraw();
        mem_wready_i = 1'b1;
        tick();
        mem_wready_i = 1'b0;
        check("rr_in_resp", busy_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rr_wvalid", mem_wvalid_o, 0);
        check("rr_busy",   busy_o,       0);
        check("rr_done",   done_o,       0);
        check("rr_waddr",  mem_waddr_o,  0);
        mem_bvalid_i = 1'b1;
        tick();
        mem_bvalid_i = 1'b0;
        check("rr_late_b", done_o, 0);

`ifdef STORE_TIMEOUT_EN
        begin
            int n;
            present(32'h0000_8000, 32'h8888_8888, 3'b100);
            tick();
            withdraw();
            n = 0;
            while (mem_wvalid_o && n < 50) begin
                n++;
                tick();
            end
            check("to_cycles", n,      8);
            check("to_done",   done_o, 1);
            check("to_err",    err_o,  1);
            check("to_idle",   busy_o, 0);
            mem_bvalid_i = 1'b1;
            tick();
            mem_bvalid_i = 1'b0;
            check("to_late_b", done_o, 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
